silly_tap_sequencer: RTL

//  Programmable sequencer for the divide-by-2^n signal generator family.

---
 rtl/silly_tap_sequencer_if.sv | 30 +++
 rtl/silly_tap_sequencer.sv | 110 +++++++++++
 2 files changed

// File: rtl/silly_tap_sequencer_if.sv
// rtl/silly_tap_sequencer_if.sv - table-write, control and wave bus of the tap sequencer
interface silly_tap_sequencer_if #(
  parameter int STEPS  = 8,
  parameter int HOLD_W = 8
);
  localparam int SW = $clog2(STEPS);

  logic              wr_en;
  logic [SW-1:0]     wr_addr;
  logic [2:0]        wr_tap;
  logic [HOLD_W-1:0] wr_hold;
  logic [SW-1:0]     last_step;
  logic              loop;
  logic              start;
  logic              stop;
  logic              wave_out;
  logic              busy;
  logic              done;
  logic [SW-1:0]     step_idx;

  modport master (
    output wr_en, wr_addr, wr_tap, wr_hold, last_step, loop, start, stop,
    input  wave_out, busy, done, step_idx
  );

  modport slave (
    input  wr_en, wr_addr, wr_tap, wr_hold, last_step, loop, start, stop,
    output wave_out, busy, done, step_idx
  );
endinterface

// File: rtl/silly_tap_sequencer.sv
// rtl/silly_tap_sequencer.sv - steps a {tap, hold} table over an 8-bit prescaler
// Each step plays prescaler bit cur_tap for cur_hold+1 full periods; changes land on period ends.
module silly_tap_sequencer #(
  parameter int STEPS  = 8,
  parameter int HOLD_W = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  silly_tap_sequencer_if.slave  bus
);
  localparam int SW = $clog2(STEPS);
  localparam logic [SW:0] STEPS_W  = (SW+1)'(STEPS);
  localparam logic [SW:0] STEP_MAX = (SW+1)'(STEPS - 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t            state_q;
  logic [7:0]        cnt_q;
  logic [HOLD_W-1:0] per_cnt_q;
  logic [SW-1:0]     step_q;
  logic [SW-1:0]     last_q;
  logic [2:0]        cur_tap_q;
  logic [HOLD_W-1:0] cur_hold_q;
  logic              done_q;
  logic [2:0]        tap_tbl_q  [STEPS];
  logic [HOLD_W-1:0] hold_tbl_q [STEPS];

  logic [7:0]    tap_mask;
  logic          period_end;
  logic          wr_ok;
  logic [SW-1:0] next_idx;
  logic [SW-1:0] last_clamped;

  // Low cur_tap+1 bits all ones marks the final cycle of one tap period.
  assign tap_mask     = 8'hFF >> (3'd7 - cur_tap_q);
  assign period_end   = (cnt_q & tap_mask) == tap_mask;
  assign wr_ok        = bus.wr_en && ({1'b0, bus.wr_addr} < STEPS_W);
  assign next_idx     = step_q + SW'(1);
  assign last_clamped = ({1'b0, bus.last_step} > STEP_MAX) ? STEP_MAX[SW-1:0] : bus.last_step;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      per_cnt_q  <= '0;
      step_q     <= '0;
      last_q     <= '0;
      cur_tap_q  <= '0;
      cur_hold_q <= '0;
      done_q     <= 1'b0;
      for (int i = 0; i < STEPS; i++) begin
        tap_tbl_q[i]  <= '0;
        hold_tbl_q[i] <= '0;
      end
    end else begin
      done_q <= 1'b0;
      // Entry latches below read the pre-write table, so a write to the active entry waits for its next visit.
      if (wr_ok) begin
        tap_tbl_q[bus.wr_addr]  <= bus.wr_tap;
        hold_tbl_q[bus.wr_addr] <= bus.wr_hold;
      end
      case (state_q)
        IDLE: begin
          if (bus.start && !bus.stop) begin
            state_q    <= RUN;
            cnt_q      <= '0;
            per_cnt_q  <= '0;
            step_q     <= '0;
            last_q     <= last_clamped;
            cur_tap_q  <= tap_tbl_q[0];
            cur_hold_q <= hold_tbl_q[0];
          end
        end
        RUN: begin
          if (bus.stop) begin
            state_q <= IDLE;
            step_q  <= '0;
          end else if (!period_end) begin
            cnt_q <= cnt_q + 8'd1;
          end else if (per_cnt_q != cur_hold_q) begin
            per_cnt_q <= per_cnt_q + HOLD_W'(1);
            cnt_q     <= cnt_q + 8'd1;
          end else begin
            cnt_q     <= '0;
            per_cnt_q <= '0;
            if (step_q != last_q) begin
              step_q     <= next_idx;
              cur_tap_q  <= tap_tbl_q[next_idx];
              cur_hold_q <= hold_tbl_q[next_idx];
            end else if (bus.loop) begin
              step_q     <= '0;
              cur_tap_q  <= tap_tbl_q[0];
              cur_hold_q <= hold_tbl_q[0];
            end else begin
              state_q <= IDLE;
              step_q  <= '0;
              done_q  <= 1'b1;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.busy     = (state_q == RUN);
  assign bus.wave_out = (state_q == RUN) & cnt_q[cur_tap_q];
  assign bus.done     = done_q;
  assign bus.step_idx = step_q;
endmodule
